// File: rtl/rot_pkg.sv
// rot_pkg: shared types and constants for the rotator scheduler.
// State encoding, rotate direction and requester ID values.
package rot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic ROT_LEFT  = 1'b1;
    localparam logic ROT_RIGHT = 1'b0;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/rot_step.sv
// rot_step: combinational single-position rotate, the shared datapath
// sequenced by rot_sched.
module rot_step
    import rot_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_word
);

    assign o_word = (i_dir == ROT_LEFT)
                  ? {i_word[WIDTH-2:0], i_word[WIDTH-1]}
                  : {i_word[0], i_word[WIDTH-1:1]};

endmodule

// File: rtl/rot_sched.sv
// rot_sched: two-requester scheduler for a shared one-bit-per-cycle rotator.
// Define ROT_RR_ARB_EN for round-robin arbitration; default is fixed priority.
module rot_sched
    import rot_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_dir,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_dir,
    input  logic [AMT_W-1:0] req1_amt,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_id,
    output logic             busy
);

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_word;
    logic              r_dir;
    logic [AMT_W-1:0]  r_cnt;
    logic              r_id;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_accept;
    logic [WIDTH-1:0]  w_sel_data;
    logic              w_sel_dir;
    logic [AMT_W-1:0]  w_sel_amt;
    logic [WIDTH-1:0]  w_rot_word;

`ifdef ROT_RR_ARB_EN
    logic r_last;

    // Contention goes to whoever was not served last
    assign w_grant0 = req0_valid & (~req1_valid | (r_last == ID_REQ1));
    assign w_grant1 = req1_valid & (~req0_valid | (r_last == ID_REQ0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= ID_REQ1;
        end else if (w_accept) begin
            r_last <= w_grant1 ? ID_REQ1 : ID_REQ0;
        end
    end
`else
    assign w_grant0 = req0_valid;
    assign w_grant1 = req1_valid & ~req0_valid;
`endif

    assign w_accept   = (r_state == IDLE) & (w_grant0 | w_grant1);
    assign w_sel_data = w_grant1 ? req1_data : req0_data;
    assign w_sel_dir  = w_grant1 ? req1_dir  : req0_dir;
    assign w_sel_amt  = w_grant1 ? req1_amt  : req0_amt;

    rot_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_word (r_word),
        .i_dir  (r_dir),
        .o_word (w_rot_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (w_sel_amt != '0) ? ROT : DONE;
                end
            end
            ROT: begin
                if (r_cnt == AMT_W'(1)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
            r_dir  <= ROT_RIGHT;
            r_cnt  <= '0;
            r_id   <= ID_REQ0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_word <= w_sel_data;
                        r_dir  <= w_sel_dir;
                        r_cnt  <= w_sel_amt;
                        r_id   <= w_grant1 ? ID_REQ1 : ID_REQ0;
                    end
                end
                ROT: begin
                    r_word <= w_rot_word;
                    r_cnt  <= r_cnt - AMT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced low for as long as reset is held
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_id    = 1'b0;
        busy       = 1'b0;
        if (!rst) begin
            req0_ready = (r_state == IDLE) & w_grant0;
            req1_ready = (r_state == IDLE) & w_grant1;
            resp_valid = (r_state == DONE);
            resp_data  = r_word;
            resp_id    = r_id;
            busy       = (r_state != IDLE);
        end
    end

endmodule
